// File: rtl/spi_mem_bridge.sv
// rtl/spi_mem_bridge.sv - SPI command word executor driving a single-outstanding SDRAM request port
module spi_mem_bridge #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ucSEL_,
    input  logic [63:0] cmd_word,
    output logic [63:0] status_word,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;
    localparam logic [3:0] OP_FILL  = 4'd3;
    localparam logic [3:0] OP_CHECK = 4'd4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_NEXT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       op_q, op_d;
    logic [11:0]      remaining_q, remaining_d;
    logic [23:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic             busy_q, busy_d;
    logic             bad_op_q, bad_op_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       last_op_q, last_op_d;
    logic [15:0]      mism_q, mism_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [63:0]      status_q, status_d;

    logic [3:0]       cmd_op;
    logic             ack_ok;
    logic             wdog_last;

    assign cmd_op      = cmd_word[63:60];
    // The first ISSUE cycle after IDLE has mem_req still low, so only acks against a live request count.
    assign ack_ok      = mem_ack && mem_req_q;
    assign wdog_last   = (wdog_q == WDW'(TIMEOUT - 1));

    assign status_word = status_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q && mem_req_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = data_q;

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[1:0], ucSEL_};
        strobe_d    = (sync_q[2:1] == 2'b01);
        op_d        = op_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wdog_d      = wdog_q;
        busy_d      = busy_q;
        bad_op_d    = bad_op_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        last_op_d   = last_op_q;
        mism_d      = mism_q;
        rdata_d     = rdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        status_d    = {busy_q, bad_op_q, overrun_q, timeout_q, last_op_q,
                       addr_q, mism_q, rdata_q};

        if (strobe_q && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (strobe_q) begin
                    last_op_d = cmd_op;
                    if (cmd_op != OP_NOP) begin
                        bad_op_d  = 1'b0;
                        overrun_d = 1'b0;
                        timeout_d = 1'b0;
                        if (cmd_op > OP_CHECK) begin
                            bad_op_d = 1'b1;
                        end else begin
                            op_d        = cmd_op;
                            addr_d      = cmd_word[47:24];
                            data_d      = cmd_word[15:0];
                            remaining_d = (cmd_op == OP_FILL || cmd_op == OP_CHECK)
                                          ? cmd_word[59:48] : 12'd0;
                            mem_we_d    = (cmd_op == OP_WRITE || cmd_op == OP_FILL);
                            busy_d      = 1'b1;
                            state_d     = S_ISSUE;
                            if (cmd_op == OP_CHECK) begin
                                mism_d = '0;
                            end
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (ack_ok) begin
                    if (op_q == OP_READ || op_q == OP_CHECK) begin
                        rdata_d = mem_rdata;
                    end
                    if (op_q == OP_CHECK && mem_rdata != data_q && mism_q != 16'hFFFF) begin
                        mism_d = mism_q + 16'd1;
                    end
                    wdog_d  = '0;
                    state_d = S_NEXT;
                end else if (mem_req_q && wdog_last) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    wdog_d    = '0;
                    state_d   = S_IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    if (mem_req_q) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            S_NEXT: begin
                wdog_d = '0;
                if (remaining_q == 12'd0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    remaining_d = remaining_q - 12'd1;
                    addr_d      = addr_q + 24'd1;
                    mem_req_d   = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= 3'b111;
            strobe_q    <= 1'b0;
            op_q        <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wdog_q      <= '0;
            busy_q      <= 1'b0;
            bad_op_q    <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            last_op_q   <= '0;
            mism_q      <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            strobe_q    <= strobe_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wdog_q      <= wdog_d;
            busy_q      <= busy_d;
            bad_op_q    <= bad_op_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            last_op_q   <= last_op_d;
            mism_q      <= mism_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            status_q    <= status_d;
        end
    end
endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb/tb_spi_mem_bridge.sv - table-driven self-checking bench for spi_mem_bridge
module tb_spi_mem_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ucSEL_;
    logic [63:0] cmd_word;
    logic [63:0] status_word;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    spi_mem_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .ucSEL_(ucSEL_), .cmd_word(cmd_word),
        .status_word(status_word), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic [63:0] cmd;
        bit          ack_en;
        int          delay;
        int          n_acc;
        bit          exp_we;
        logic [23:0] start;
        logic [15:0] wdata;
        int          req_cyc;
        logic [63:0] exp_status;
    } vec_t;

    acc_t acc_log[$];
    int   passed = 0;
    int   total  = 0;
    bit   ack_en = 1'b1;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    int   req_cycles = 0;

    function automatic logic [15:0] mem_model(input logic [23:0] a);
        if (a >= 24'h10 && a <= 24'h17) begin
            if (a == 24'h12) return 16'hDEAD;
            if (a == 24'h15) return 16'h0BAD;
            return 16'h1234;
        end
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [63:0] mkcmd(input logic [3:0] op, input logic [11:0] cnt,
                                          input logic [23:0] a, input logic [15:0] d);
        return {op, cnt, a, 8'h00, d};
    endfunction

    function automatic logic [63:0] mkst(input bit b, input bit bad, input bit ov, input bit to,
                                         input logic [3:0] op, input logic [23:0] a,
                                         input logic [15:0] mm, input logic [15:0] rd);
        return {b, bad, ov, to, op, a, mm, rd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Memory responder: acks after ack_delay+1 sampled request cycles, logs each acked access.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            req_cycles++;
            if (ack_en && wait_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
                acc_log.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic sel_pulse();
        @(negedge clk);
        ucSEL_ = 1'b0;
        repeat (4) @(negedge clk);
        ucSEL_ = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (status_word[63] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            total++;
            $display("FAIL %s: busy still set after %0d cycles, required clear", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [63:0] c, input string name);
        cmd_word = c;
        sel_pulse();
        repeat (10) @(negedge clk);
        wait_idle(name);
    endtask

    vec_t vecs[9];

    initial begin
        int errs;
        int n;

        vecs[0] = '{mkcmd(4'h1, 12'd0, 24'h000100, 16'hBEEF), 1, 3, 1, 1, 24'h000100, 16'hBEEF, 4,
                    mkst(0, 0, 0, 0, 4'h1, 24'h000100, 16'h0, 16'h0)};
        vecs[1] = '{mkcmd(4'h2, 12'd0, 24'h000200, 16'h0000), 1, 0, 1, 0, 24'h000200, 16'h0, 1,
                    mkst(0, 0, 0, 0, 4'h2, 24'h000200, 16'h0, 16'hA7A5)};
        vecs[2] = '{mkcmd(4'h3, 12'd3, 24'hFFFFFE, 16'h5A5A), 1, 1, 4, 1, 24'hFFFFFE, 16'h5A5A, 8,
                    mkst(0, 0, 0, 0, 4'h3, 24'h000001, 16'h0, 16'hA7A5)};
        vecs[3] = '{mkcmd(4'h4, 12'd7, 24'h000010, 16'h1234), 1, 0, 8, 0, 24'h000010, 16'h0, 8,
                    mkst(0, 0, 0, 0, 4'h4, 24'h000017, 16'd2, 16'h1234)};
        vecs[4] = '{mkcmd(4'h2, 12'd0, 24'h000300, 16'h0000), 0, 0, 0, 0, 24'h000300, 16'h0, 16,
                    mkst(0, 0, 0, 1, 4'h2, 24'h000300, 16'd2, 16'h1234)};
        vecs[5] = '{mkcmd(4'h2, 12'd0, 24'h000010, 16'h0000), 1, 2, 1, 0, 24'h000010, 16'h0, 3,
                    mkst(0, 0, 0, 0, 4'h2, 24'h000010, 16'd2, 16'h1234)};
        vecs[6] = '{mkcmd(4'h7, 12'd0, 24'h000400, 16'h0000), 1, 0, 0, 0, 24'h0, 16'h0, 0,
                    mkst(0, 1, 0, 0, 4'h7, 24'h000010, 16'd2, 16'h1234)};
        vecs[7] = '{mkcmd(4'h2, 12'd0, 24'h000020, 16'h0000), 1, 15, 1, 0, 24'h000020, 16'h0, 16,
                    mkst(0, 0, 0, 0, 4'h2, 24'h000020, 16'd2, 16'hA585)};
        vecs[8] = '{mkcmd(4'h0, 12'd5, 24'h000999, 16'hFFFF), 1, 0, 0, 0, 24'h0, 16'h0, 0,
                    mkst(0, 0, 0, 0, 4'h0, 24'h000020, 16'd2, 16'hA585)};

        rst_n = 1'b0; ucSEL_ = 1'b1; cmd_word = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset status", status_word, 64'h0);
        chk("reset req", {63'h0, mem_req}, 64'h0);
        chk("reset addr", {40'h0, mem_addr}, 64'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no strobe after release", {32'h0, req_cycles} | status_word, 64'h0);

        for (int v = 0; v < 9; v++) begin
            acc_log.delete();
            req_cycles = 0;
            ack_en     = vecs[v].ack_en;
            ack_delay  = vecs[v].delay;
            run_cmd(vecs[v].cmd, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d status", v), status_word, vecs[v].exp_status);
            chk($sformatf("vec%0d accesses", v), 64'(acc_log.size()), 64'(vecs[v].n_acc));
            chk($sformatf("vec%0d req cycles", v), 64'(req_cycles), 64'(vecs[v].req_cyc));
            for (int i = 0; i < acc_log.size(); i++) begin
                chk($sformatf("vec%0d acc%0d addr", v, i), {40'h0, acc_log[i].addr},
                    {40'h0, vecs[v].start + 24'(i)});
                chk($sformatf("vec%0d acc%0d we", v, i), {63'h0, acc_log[i].we},
                    {63'h0, vecs[v].exp_we});
                if (vecs[v].exp_we)
                    chk($sformatf("vec%0d acc%0d wdata", v, i), {48'h0, acc_log[i].wdata},
                        {48'h0, vecs[v].wdata});
            end
        end

        // Second select during a long FILL: dropped, flagged, FILL runs to completion.
        acc_log.delete();
        ack_en = 1'b1; ack_delay = 1;
        cmd_word = mkcmd(4'h3, 12'd100, 24'h001000, 16'h7777);
        sel_pulse();
        repeat (30) @(negedge clk);
        chk("fill busy mid-run", {63'h0, status_word[63]}, 64'h1);
        cmd_word = mkcmd(4'h1, 12'd0, 24'h005000, 16'h1111);
        sel_pulse();
        repeat (10) @(negedge clk);
        wait_idle("overrun fill");
        chk("overrun flag", {63'h0, status_word[61]}, 64'h1);
        chk("overrun last op", {60'h0, status_word[59:56]}, 64'h3);
        chk("overrun last addr", {40'h0, status_word[55:32]}, 64'h001064);
        chk("overrun accesses", 64'(acc_log.size()), 64'd101);
        errs = 0;
        for (int i = 0; i < acc_log.size(); i++)
            if (acc_log[i].addr != 24'h001000 + 24'(i) || !acc_log[i].we || acc_log[i].wdata != 16'h7777)
                errs++;
        chk("overrun access contents errors", 64'(errs), 64'd0);

        // Asynchronous reset in the middle of a FILL.
        acc_log.delete();
        cmd_word = mkcmd(4'h3, 12'd50, 24'h000000, 16'h0001);
        sel_pulse();
        n = 0;
        while (!(mem_req && acc_log.size() >= 5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid-fill req seen", {63'h0, mem_req}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset req", {63'h0, mem_req}, 64'h0);
        chk("async reset status", status_word, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        req_cycles = 0;
        repeat (20) @(negedge clk);
        chk("post reset no req", 64'(req_cycles), 64'd0);
        chk("post reset status", status_word, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

Command executor sitting directly behind the SPI peek/poke slave in the SDRAM test design. It takes the 64-bit word the microcontroller shifts in, decodes it as a memory command, and runs it against the SDRAM controller's single-outstanding request port. Commands are NOP, WRITE, READ, FILL and CHECK. It maintains a 64-bit status word that the SPI slave loads as its outgoing data at the start of the next SPI transaction.

## Interface
- `TIMEOUT`, default 1024: cycles to wait for `mem_ack` before abandoning a request.
- `clk` in 1: system clock, the same clock as the SPI slave.
- `rst_n` in 1: asynchronous, active-low reset.
- `ucSEL_` in 1: raw SPI select pin, the same net the SPI slave sees; synchronized internally.
- `cmd_word` in 64: command word from the SPI slave's `data_out`.
- `status_word` out 64: status word to the SPI slave's `data_in`.
- `mem_req` out 1: request to the SDRAM controller; held until acked.
- `mem_we` out 1: 1 = write, 0 = read; stable while `mem_req` is high.
- `mem_addr` out 24: word address; stable while `mem_req` is high.
- `mem_wdata` out 16: write data; stable while `mem_req` is high.
- `mem_ack` in 1: one-cycle pulse; completes the pending request.
- `mem_rdata` in 16: read data; valid in the `mem_ack` cycle of a read.

## Operation
- Command fields:
  - [63:60] op: 0 NOP, 1 WRITE, 2 READ, 3 FILL, 4 CHECK; 5..15 are illegal.
  - [59:48] cnt: word count is cnt+1, so 1..4096; used by FILL and CHECK only.
  - [47:24] addr.
  - [23:16] ignored.
  - [15:0] data.
- Status fields:
  - [63] busy.
  - [62] bad_op.
  - [61] overrun.
  - [60] timeout.
  - [59:56] last accepted op.
  - [55:32] address of the most recent access.
  - [31:16] mismatch count.
  - [15:0] last read data.
- Command strobe:
  - `ucSEL_` passes through a 3-flop synchronizer, identical to the SPI slave's.
  - Rising edge detect (sync[2:1]==01) is delayed one cycle to give `cmd_strobe`.
  - `cmd_word` is sampled in the `cmd_strobe` cycle.
- States:
  - IDLE: on `cmd_strobe`, latch the fields and clear bad_op, overrun and timeout. Then by op:
    - NOP: stay in IDLE; only last-op updates.
    - Illegal op: set bad_op, stay in IDLE.
    - CHECK: also clear the mismatch count.
    - WRITE, READ, FILL, CHECK: go to ISSUE, set busy, remaining = 0 for WRITE/READ or cnt for FILL/CHECK.
  - ISSUE: `mem_req`=1; `mem_we`=1 for WRITE/FILL. Address reg drives `mem_addr`; data field drives `mem_wdata`. On `mem_ack`:
    - READ: capture `mem_rdata` into last read data.
    - CHECK: capture `mem_rdata`; if it differs from the data field, increment the mismatch count, saturating at 0xFFFF.
    - Then go to NEXT.
  - ISSUE timeout: if the watchdog reaches TIMEOUT with no ack, set timeout, drop `mem_req`, clear busy and go to IDLE. The rest of the command is abandoned.
  - NEXT: if remaining==0, clear busy and go to IDLE. Otherwise decrement remaining, increment the address modulo 2^24 (0xFFFFFF wraps to 0x000000) and go to ISSUE.
- Overrun: a `cmd_strobe` while not IDLE is dropped, the running command continues, and overrun is set (sticky until the next accepted command).
- An ack while in IDLE or NEXT is ignored.

## Timing
- Reset values:
  - All outputs are 0; `status_word` = 0.
  - State is IDLE; counters and watchdog are 0.
  - Synchronizer flops reset to 3'b111 (deselected), so no strobe occurs at reset release.
- `mem_req` rises 2 cycles after the `cmd_strobe` cycle (latch, then ISSUE registered output).
- Per access: ISSUE lasts at least 1 cycle. `mem_req` falls the cycle after `mem_ack`. The next `mem_req` rises 2 cycles after `mem_ack` (NEXT, then ISSUE).
- `mem_ack` and the watchdog reaching TIMEOUT in the same cycle: the ack wins, and no timeout is flagged.
- The watchdog restarts at 0 on every entry to ISSUE.
- `status_word` is a registered output and updates the cycle after any field change. The SPI slave samples it at the next select falling edge, so the host sees the result one transaction later.
- `rst_n` asserted mid-command: all outputs are 0 immediately (asynchronous), and the command is lost.

## Test plan
- WRITE addr 0x000100 data 0xBEEF, ack delay 3 -> one `mem_req` with we=1, addr 0x000100, wdata 0xBEEF. Status [63]=0, [55:32]=0x000100.
- FILL addr 0xFFFFFE cnt 3 data 0x5A5A -> 4 writes to 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001. Busy stays high until after the 4th ack.
- CHECK addr 0x10 cnt 7 data 0x1234, memory model returning 0x1234 except at 0x12 and 0x15 -> mismatch count = 2; last read data = value at 0x17.
- READ with no ack, TIMEOUT=16 -> `mem_req` drops after 16 cycles; status [60]=1, [63]=0. A following READ with an ack clears [60].
- Op 0x7 -> no `mem_req`, [62]=1. A second select pulse during a FILL cnt 100 -> [61]=1 and all 101 writes complete.
- Assert `rst_n` low during FILL -> `mem_req`=0 and `status_word`=0 at once. No strobe after release while `ucSEL_` stays high.
